fetch_stage: RTL and testbench

Instruction-fetch stage of the pipelined RV32I core. It owns the program counter and drives the instruction memory address. It predicts the next PC with a small direct-mapped branch target buffer (BTB) that uses 2-bit saturating counters. It registers the fetched instruction into the IF/ID pipeline register, with stall, flush and mispredict-recovery control.

---
 rtl/fetch_stage.sv | 207 ++++++++++++++++++++
 tb/tb_fetch_stage.sv | 321 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, predicts the next PC with a direct-mapped BTB of
// 2-bit saturating counters, and registers the fetched instruction into IF/ID.
module fetch_stage #(
   parameter logic [31:0] RESET_PC    = 32'h0000_0000,
   parameter int unsigned BTB_ENTRIES = 16
) (
   input  logic        clk_i,
   input  logic        rst_i,
   // hazard control
   input  logic        stall_f_i,
   input  logic        stall_d_i,
   input  logic        flush_d_i,
   // instruction memory
   output logic [31:0] pc_f_o,
   input  logic [31:0] instr_f_i,
   // IF/ID register
   output logic [31:0] instr_d_o,
   output logic [31:0] pc_d_o,
   output logic [31:0] pc_plus4_d_o,
   output logic [31:0] pred_npc_d_o,
   output logic        pred_taken_d_o,
   output logic        valid_d_o,
   // branch resolution from Execute
   input  logic        resolve_e_i,
   input  logic [31:0] pc_e_i,
   input  logic [31:0] target_e_i,
   input  logic [31:0] pred_npc_e_i,
   input  logic        taken_e_i,
   output logic        mispredict_e_o
);

   localparam int unsigned Idx  = $clog2(BTB_ENTRIES);
   localparam int unsigned TagW = 30 - Idx;
   localparam logic [31:0] Nop  = 32'h0000_0013;

   // ------------------------------------------------------------------
   // State
   // ------------------------------------------------------------------
   logic [31:0]     pc_f_q, pc_f_d;

   logic            btb_valid_q  [BTB_ENTRIES];
   logic [1:0]      btb_ctr_q    [BTB_ENTRIES];
   logic [TagW-1:0] btb_tag_q    [BTB_ENTRIES];
   logic [31:0]     btb_target_q [BTB_ENTRIES];

   logic [31:0]     instr_q, instr_d;
   logic [31:0]     pc_q, pc_d;
   logic [31:0]     pc_plus4_q, pc_plus4_d;
   logic [31:0]     pred_npc_q, pred_npc_d;
   logic            pred_taken_q, pred_taken_d;
   logic            valid_q, valid_d;

   // ------------------------------------------------------------------
   // BTB lookup (fetch side, combinational on the current PC)
   // ------------------------------------------------------------------
   logic [Idx-1:0]  idx_f;
   logic [TagW-1:0] tag_f;
   logic            hit_f;
   logic            pred_taken_f;
   logic [31:0]     pc_plus4_f;
   logic [31:0]     pred_npc_f;

   assign idx_f        = pc_f_q[Idx+1:2];
   assign tag_f        = pc_f_q[31:Idx+2];
   assign hit_f        = btb_valid_q[idx_f] && (btb_tag_q[idx_f] == tag_f);
   assign pred_taken_f = hit_f && btb_ctr_q[idx_f][1];
   assign pc_plus4_f   = pc_f_q + 32'd4;
   assign pred_npc_f   = pred_taken_f ? btb_target_q[idx_f] : pc_plus4_f;

   // ------------------------------------------------------------------
   // Resolution and mispredict detection
   // ------------------------------------------------------------------
   logic [31:0]     actual_npc_e;
   logic            mispredict_e;

   assign actual_npc_e   = taken_e_i ? target_e_i : (pc_e_i + 32'd4);
   assign mispredict_e   = resolve_e_i && (actual_npc_e != pred_npc_e_i);
   assign mispredict_e_o = mispredict_e;

   // ------------------------------------------------------------------
   // BTB update (execute side)
   // ------------------------------------------------------------------
   logic [Idx-1:0]  idx_e;
   logic [TagW-1:0] tag_e;
   logic            hit_e;
   logic            upd_en;
   logic [1:0]      upd_ctr;

   assign idx_e = pc_e_i[Idx+1:2];
   assign tag_e = pc_e_i[31:Idx+2];
   assign hit_e = btb_valid_q[idx_e] && (btb_tag_q[idx_e] == tag_e);

   always_comb begin
      upd_en  = 1'b0;
      upd_ctr = btb_ctr_q[idx_e];
      if (resolve_e_i) begin
         if (taken_e_i) begin
            upd_en = 1'b1;
            if (!hit_e) begin
               upd_ctr = 2'b10;
            end else if (btb_ctr_q[idx_e] != 2'b11) begin
               upd_ctr = btb_ctr_q[idx_e] + 2'd1;
            end
         end else if (hit_e) begin
            // not-taken misses leave the table untouched
            upd_en = 1'b1;
            if (btb_ctr_q[idx_e] != 2'b00) begin
               upd_ctr = btb_ctr_q[idx_e] - 2'd1;
            end
         end
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         btb_valid_q <= '{default: 1'b0};
         btb_ctr_q   <= '{default: 2'b01};
      end else if (upd_en) begin
         btb_valid_q[idx_e] <= 1'b1;
         btb_ctr_q[idx_e]   <= upd_ctr;
      end
   end

   // Tag and target are qualified by the valid bit, so they need no reset.
   always_ff @(posedge clk_i) begin
      if (!rst_i && resolve_e_i && taken_e_i) begin
         btb_tag_q[idx_e]    <= tag_e;
         btb_target_q[idx_e] <= target_e_i;
      end
   end

   // ------------------------------------------------------------------
   // Program counter
   // ------------------------------------------------------------------
   always_comb begin
      pc_f_d = pred_npc_f;
      if (mispredict_e) begin
         pc_f_d = actual_npc_e;
      end else if (stall_f_i) begin
         pc_f_d = pc_f_q;
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         pc_f_q <= RESET_PC;
      end else begin
         pc_f_q <= pc_f_d;
      end
   end

   assign pc_f_o = pc_f_q;

   // ------------------------------------------------------------------
   // IF/ID pipeline register
   // ------------------------------------------------------------------
   always_comb begin
      instr_d      = instr_q;
      pc_d         = pc_q;
      pc_plus4_d   = pc_plus4_q;
      pred_npc_d   = pred_npc_q;
      pred_taken_d = pred_taken_q;
      valid_d      = valid_q;
      if (flush_d_i || mispredict_e) begin
         // a mispredict squashes the wrong-path instruction currently in F
         instr_d      = Nop;
         pc_d         = 32'h0;
         pc_plus4_d   = 32'h0;
         pred_npc_d   = 32'h0;
         pred_taken_d = 1'b0;
         valid_d      = 1'b0;
      end else if (!stall_d_i) begin
         instr_d      = instr_f_i;
         pc_d         = pc_f_q;
         pc_plus4_d   = pc_plus4_f;
         pred_npc_d   = pred_npc_f;
         pred_taken_d = pred_taken_f;
         valid_d      = 1'b1;
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         instr_q      <= Nop;
         pc_q         <= 32'h0;
         pc_plus4_q   <= 32'h0;
         pred_npc_q   <= 32'h0;
         pred_taken_q <= 1'b0;
         valid_q      <= 1'b0;
      end else begin
         instr_q      <= instr_d;
         pc_q         <= pc_d;
         pc_plus4_q   <= pc_plus4_d;
         pred_npc_q   <= pred_npc_d;
         pred_taken_q <= pred_taken_d;
         valid_q      <= valid_d;
      end
   end

   assign instr_d_o      = instr_q;
   assign pc_d_o         = pc_q;
   assign pc_plus4_d_o   = pc_plus4_q;
   assign pred_npc_d_o   = pred_npc_q;
   assign pred_taken_d_o = pred_taken_q;
   assign valid_d_o      = valid_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: scenario tasks with a queue of expected IF/ID
// contents pushed at fetch time and compared one edge later.
module tb_fetch_stage;

   logic        clk;
   logic        rst;
   logic        stall_f, stall_d, flush_d;
   logic [31:0] pc_f, instr_f;
   logic [31:0] instr_d, pc_d, pc_plus4_d, pred_npc_d;
   logic        pred_taken_d, valid_d;
   logic        resolve_e, taken_e, mispredict_e;
   logic [31:0] pc_e, target_e, pred_npc_e;

   int checks   = 0;
   int failures = 0;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] instr;
      logic        taken;
      logic [31:0] npc;
   } exp_t;

   exp_t sb[$];

   fetch_stage #(
      .RESET_PC   (32'h0000_0000),
      .BTB_ENTRIES(16)
   ) dut (
      .clk_i         (clk),
      .rst_i         (rst),
      .stall_f_i     (stall_f),
      .stall_d_i     (stall_d),
      .flush_d_i     (flush_d),
      .pc_f_o        (pc_f),
      .instr_f_i     (instr_f),
      .instr_d_o     (instr_d),
      .pc_d_o        (pc_d),
      .pc_plus4_d_o  (pc_plus4_d),
      .pred_npc_d_o  (pred_npc_d),
      .pred_taken_d_o(pred_taken_d),
      .valid_d_o     (valid_d),
      .resolve_e_i   (resolve_e),
      .pc_e_i        (pc_e),
      .target_e_i    (target_e),
      .pred_npc_e_i  (pred_npc_e),
      .taken_e_i     (taken_e),
      .mispredict_e_o(mispredict_e)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [31:0] imem(input logic [31:0] a);
      return {a[15:0] ^ 16'h5A5A, 16'h1233};
   endfunction

   always_comb instr_f = imem(pc_f);

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_resolve();
      resolve_e  = 1'b0;
      taken_e    = 1'b0;
      pc_e       = 32'h0;
      target_e   = 32'h0;
      pred_npc_e = 32'h0;
   endtask

   // Not-taken resolve of t-4 with a bogus prediction: forces PCF to t, no BTB allocation.
   task automatic redirect(input logic [31:0] t);
      resolve_e  = 1'b1;
      taken_e    = 1'b0;
      pc_e       = t - 32'd4;
      target_e   = 32'h0;
      pred_npc_e = 32'hDEAD_BEEC;
      step();
      clear_resolve();
   endtask

   task automatic test_reset();
      rst = 1'b1;
      #1;
      checks++;
      if ({pc_f, valid_d, instr_d, pc_d, pred_npc_d} !== {32'h0, 1'b0, 32'h13, 32'h0, 32'h0}) begin
         failures++;
         $display("FAIL reset_state: got pc=%h v=%b i=%h pcd=%h npc=%h want 0/0/13/0/0",
                  pc_f, valid_d, instr_d, pc_d, pred_npc_d);
      end
      checks++;
      if (mispredict_e !== 1'b0) begin
         failures++;
         $display("FAIL reset_mispredict: got %b want 0", mispredict_e);
      end
      step();
      step();
      rst = 1'b0;
   endtask

   task automatic test_sequential();
      logic [31:0] pc;
      exp_t e;
      pc = 32'h0;
      for (int i = 0; i < 4; i++) begin
         checks++;
         if (pc_f !== pc) begin
            failures++;
            $display("FAIL seq_pcf: got %h want %h", pc_f, pc);
         end
         sb.push_back('{pc: pc, instr: imem(pc), taken: 1'b0, npc: pc + 32'd4});
         step();
         e = sb.pop_front();
         checks++;
         if ({valid_d, pc_d, instr_d, pc_plus4_d, pred_taken_d, pred_npc_d} !==
             {1'b1, e.pc, e.instr, e.pc + 32'd4, e.taken, e.npc}) begin
            failures++;
            $display("FAIL seq_ifid: got v=%b pc=%h i=%h p4=%h t=%b npc=%h want pc=%h i=%h npc=%h",
                     valid_d, pc_d, instr_d, pc_plus4_d, pred_taken_d, pred_npc_d,
                     e.pc, e.instr, e.npc);
         end
         pc += 32'd4;
      end
   endtask

   task automatic test_stall();
      checks++;
      if (pc_f !== 32'h10) begin
         failures++;
         $display("FAIL stall_start_pcf: got %h want 00000010", pc_f);
      end
      stall_f = 1'b1;
      stall_d = 1'b1;
      step();
      step();
      checks++;
      if ({pc_f, pc_d, instr_d, valid_d} !== {32'h10, 32'hC, imem(32'hC), 1'b1}) begin
         failures++;
         $display("FAIL stall_hold: got pcf=%h pcd=%h i=%h v=%b want 10/c/%h/1",
                  pc_f, pc_d, instr_d, valid_d, imem(32'hC));
      end
      stall_f = 1'b0;
      stall_d = 1'b0;
      step();
      checks++;
      if ({pc_f, pc_d, instr_d} !== {32'h14, 32'h10, imem(32'h10)}) begin
         failures++;
         $display("FAIL stall_release: got pcf=%h pcd=%h i=%h want 14/10/%h",
                  pc_f, pc_d, instr_d, imem(32'h10));
      end
   endtask

   task automatic test_mispredict();
      // PC+4 wrap: a correct not-taken prediction at the top of memory
      resolve_e = 1'b1; pc_e = 32'hFFFF_FFFC; taken_e = 1'b0; pred_npc_e = 32'h0;
      #1;
      checks++;
      if (mispredict_e !== 1'b0) begin
         failures++;
         $display("FAIL mp_wrap: got %b want 0", mispredict_e);
      end
      pc_e = 32'h20; target_e = 32'h100; taken_e = 1'b1; pred_npc_e = 32'h100;
      #1;
      checks++;
      if (mispredict_e !== 1'b0) begin
         failures++;
         $display("FAIL mp_correct_taken: got %b want 0", mispredict_e);
      end
      pred_npc_e = 32'h24;
      #1;
      checks++;
      if (mispredict_e !== 1'b1) begin
         failures++;
         $display("FAIL mp_detect: got %b want 1", mispredict_e);
      end
      step();
      clear_resolve();
      checks++;
      if ({pc_f, valid_d, instr_d, pc_d, pred_npc_d} !== {32'h100, 1'b0, 32'h13, 32'h0, 32'h0}) begin
         failures++;
         $display("FAIL mp_redirect: got pcf=%h v=%b i=%h pcd=%h npc=%h want 100/0/13/0/0",
                  pc_f, valid_d, instr_d, pc_d, pred_npc_d);
      end
   endtask

   task automatic test_training();
      exp_t e;
      // BTB[8] now holds 0x20 -> 0x100, counter 10
      redirect(32'h20);
      sb.push_back('{pc: 32'h20, instr: imem(32'h20), taken: 1'b1, npc: 32'h100});
      step();
      e = sb.pop_front();
      checks++;
      if ({pc_f, valid_d, pc_d, pred_taken_d, pred_npc_d, instr_d} !==
          {32'h100, 1'b1, e.pc, e.taken, e.npc, e.instr}) begin
         failures++;
         $display("FAIL train_taken: got pcf=%h v=%b pcd=%h t=%b npc=%h want 100/1/%h/%b/%h",
                  pc_f, valid_d, pc_d, pred_taken_d, pred_npc_d, e.pc, e.taken, e.npc);
      end
      // same index, different tag
      redirect(32'h60);
      sb.push_back('{pc: 32'h60, instr: imem(32'h60), taken: 1'b0, npc: 32'h64});
      step();
      e = sb.pop_front();
      checks++;
      if ({pc_f, pc_d, pred_taken_d, pred_npc_d} !== {32'h64, e.pc, e.taken, e.npc}) begin
         failures++;
         $display("FAIL alias_miss: got pcf=%h pcd=%h t=%b npc=%h want 64/%h/%b/%h",
                  pc_f, pc_d, pred_taken_d, pred_npc_d, e.pc, e.taken, e.npc);
      end
      // update and lookup of the same entry in one cycle: lookup sees counter 10
      redirect(32'h20);
      resolve_e = 1'b1; pc_e = 32'h20; taken_e = 1'b0; pred_npc_e = 32'h24;
      #1;
      checks++;
      if (mispredict_e !== 1'b0) begin
         failures++;
         $display("FAIL same_cycle_nomp: got %b want 0", mispredict_e);
      end
      sb.push_back('{pc: 32'h20, instr: imem(32'h20), taken: 1'b1, npc: 32'h100});
      step();
      e = sb.pop_front();
      checks++;
      if ({pc_f, pred_taken_d, pred_npc_d} !== {32'h100, e.taken, e.npc}) begin
         failures++;
         $display("FAIL same_cycle_old_ctr: got pcf=%h t=%b npc=%h want 100/%b/%h",
                  pc_f, pred_taken_d, pred_npc_d, e.taken, e.npc);
      end
      // second not-taken resolve drives the counter to 00
      step();
      clear_resolve();
      redirect(32'h20);
      sb.push_back('{pc: 32'h20, instr: imem(32'h20), taken: 1'b0, npc: 32'h24});
      step();
      e = sb.pop_front();
      checks++;
      if ({pc_f, pc_d, pred_taken_d, pred_npc_d} !== {32'h24, e.pc, e.taken, e.npc}) begin
         failures++;
         $display("FAIL train_not_taken: got pcf=%h pcd=%h t=%b npc=%h want 24/%h/%b/%h",
                  pc_f, pc_d, pred_taken_d, pred_npc_d, e.pc, e.taken, e.npc);
      end
   endtask

   task automatic test_priority();
      stall_f = 1'b1;
      stall_d = 1'b1;
      resolve_e = 1'b1; pc_e = 32'h200; taken_e = 1'b1; target_e = 32'h300; pred_npc_e = 32'h204;
      step();
      clear_resolve();
      checks++;
      if ({pc_f, valid_d} !== {32'h300, 1'b0}) begin
         failures++;
         $display("FAIL redirect_over_stall: got pcf=%h v=%b want 300/0", pc_f, valid_d);
      end
      stall_f = 1'b0;
      stall_d = 1'b0;
      step();
      checks++;
      if ({valid_d, pc_d} !== {1'b1, 32'h300}) begin
         failures++;
         $display("FAIL post_redirect_load: got v=%b pcd=%h want 1/300", valid_d, pc_d);
      end
      stall_d = 1'b1;
      flush_d = 1'b1;
      step();
      stall_d = 1'b0;
      flush_d = 1'b0;
      checks++;
      if ({valid_d, instr_d, pc_d} !== {1'b0, 32'h13, 32'h0}) begin
         failures++;
         $display("FAIL flush_over_stall: got v=%b i=%h pcd=%h want 0/13/0", valid_d, instr_d, pc_d);
      end
   endtask

   task automatic test_reset_midrun();
      @(posedge clk);
      #3;
      rst = 1'b1;
      #1;
      checks++;
      if ({pc_f, valid_d, instr_d} !== {32'h0, 1'b0, 32'h13}) begin
         failures++;
         $display("FAIL async_reset: got pcf=%h v=%b i=%h want 0/0/13", pc_f, valid_d, instr_d);
      end
      step();
      rst = 1'b0;
   endtask

   task automatic test_btb_cleared();
      // 0x200 was allocated before the mid-run reset; it must now miss
      redirect(32'h200);
      step();
      checks++;
      if ({pc_f, pred_taken_d, pc_d} !== {32'h204, 1'b0, 32'h200}) begin
         failures++;
         $display("FAIL btb_cleared: got pcf=%h t=%b pcd=%h want 204/0/200",
                  pc_f, pred_taken_d, pc_d);
      end
   endtask

   initial begin
      stall_f = 1'b0;
      stall_d = 1'b0;
      flush_d = 1'b0;
      clear_resolve();
      test_reset();
      test_sequential();
      test_stall();
      test_mispredict();
      test_training();
      test_priority();
      test_reset_midrun();
      test_sequential();
      test_btb_cleared();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
